// File: rtl/arrow_field.sv
// arrow_field: four-lane falling-note playfield for a rhythm game.
// Notes spawn at row 0 on a tempo tick, scroll down one row per tick, and
// must be struck with the lane key while they sit on row 7 (the hit row).
// The field, score, miss count and game state are all registered here.
//
// Optional feature: define ARROW_FIELD_COMBO_EN to build the consecutive-hit
// counter on combo_o. Without it combo_o is tied to zero.
module arrow_field #(
    parameter int DENSITY  = 4,   // spawn when rand_i[8:6] < DENSITY (0..8)
    parameter int MAX_MISS = 10   // miss count that ends the game (1..15)
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        tick_i,
    input  logic [8:0]  rand_i,
    input  logic [3:0]  key_i,
    output logic [31:0] field_o,
    output logic        hit_o,
    output logic        miss_o,
    output logic [7:0]  score_o,
    output logic [3:0]  misses_o,
    output logic [1:0]  state_o,
    output logic [7:0]  combo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    state_t      state_q;
    logic [31:0] field_q, field_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  misses_q, misses_d;
    logic        hit_q, miss_q;

    logic [31:0] key_field;     // field after key judgement, before scrolling
    logic [2:0]  h_cnt;         // hits this cycle, 0..4
    logic [3:0]  m_cnt;         // misses this cycle, 0..8
    logic        spawn;
    logic [8:0]  score_sum;
    logic [4:0]  miss_sum;
    logic        game_over;

    // rand_i[5:2] carries no meaning for this block; only lane and density bits are used.
    logic unused_rand;
    assign unused_rand = ^rand_i[5:2];

    assign spawn = (int'(rand_i[8:6]) < DENSITY);

    // Judge keys against the pre-shift hit row, then scroll and spawn on tick.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        key_field = field_q;
        field_d   = field_q;
        h_cnt     = 3'd0;
        m_cnt     = 4'd0;
        for (int lane = 0; lane < 4; lane++) begin
            if (key_i[lane]) begin
                if (field_q[lane*8+7]) begin
                    key_field[lane*8+7] = 1'b0;
                    h_cnt = h_cnt + 3'd1;
                end else begin
                    m_cnt = m_cnt + 4'd1;
                end
            end
        end
        field_d = key_field;
        if (tick_i) begin
            for (int lane = 0; lane < 4; lane++) begin
                // A note still on the hit row after key judgement falls off unplayed.
                if (key_field[lane*8+7]) begin
                    m_cnt = m_cnt + 4'd1;
                end
                field_d[lane*8 +: 8] = {key_field[lane*8 +: 7], 1'b0};
                if (spawn && (rand_i[1:0] == 2'(lane))) begin
                    field_d[lane*8] = 1'b1;
                end
            end
        end
    end

    // Saturating score and miss accumulation; the game ends when misses reach MAX_MISS.
    always_comb begin
        score_sum = {1'b0, score_q} + 9'(h_cnt);
        score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
        miss_sum  = {1'b0, misses_q} + 5'(m_cnt);
        game_over = (miss_sum >= 5'(MAX_MISS));
        misses_d  = game_over ? 4'(MAX_MISS) : miss_sum[3:0];
    end

`ifdef ARROW_FIELD_COMBO_EN
    logic [7:0] combo_q, combo_d;
    logic [8:0] combo_sum;

    // Consecutive-hit counter: grows on clean hit cycles, cleared by any miss.
    always_comb begin
        combo_sum = {1'b0, combo_q} + 9'(h_cnt);
        combo_d   = combo_q;
        if (m_cnt != 4'd0) begin
            combo_d = 8'd0;
        end else if (h_cnt != 3'd0) begin
            combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        end
    end

    // Combo register follows the game state: cleared on reset and on game start.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            combo_q <= 8'd0;
        end else if (state_q == ST_PLAY) begin
            combo_q <= combo_d;
        end else if (start_i) begin
            combo_q <= 8'd0;
        end
    end

    assign combo_o = combo_q;
`else
    assign combo_o = 8'd0;
`endif

    // Game state machine with registered field, counters and event pulses.
    always_ff @(posedge clock_i) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_q  <= ST_IDLE;
            field_q  <= 32'd0;
            score_q  <= 8'd0;
            misses_q <= 4'd0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    hit_q  <= 1'b0;
                    miss_q <= 1'b0;
                    if (start_i) begin
                        state_q  <= ST_PLAY;
                        field_q  <= 32'd0;
                        score_q  <= 8'd0;
                        misses_q <= 4'd0;
                    end
                end
                ST_PLAY: begin
                    field_q  <= field_d;
                    score_q  <= score_d;
                    misses_q <= misses_d;
                    hit_q    <= (h_cnt != 3'd0);
                    miss_q   <= (m_cnt != 4'd0);
                    if (game_over) begin
                        state_q <= ST_OVER;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    hit_q   <= 1'b0;
                    miss_q  <= 1'b0;
                end
            endcase
        end
    end

    assign field_o  = field_q;
    assign hit_o    = hit_q;
    assign miss_o   = miss_q;
    assign score_o  = score_q;
    assign misses_o = misses_q;
    assign state_o  = state_q;

endmodule

// File: doc/arrow_field.md
ARROW_FIELD -- requirements
Module: arrow_field

Interface
Parameters:
REQ-001 Parameter DENSITY, default 4, spawn threshold compared against Rand[8:6]; legal range 0..8.
REQ-002 Parameter MAX_MISS, default 10, miss count that ends the game; legal range 1..15.

Ports:
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  one-cycle pulse; starts or restarts a game.
REQ-006 Tick  input  1  one-cycle scroll pulse from the tempo divider.
REQ-007 Rand  input  9  free-running output of the 9-bit XNOR LFSR; sampled only on Tick.
REQ-008 Key  input  4  one-cycle, debounced press pulses, one bit per lane.
REQ-009 Field  output  32  note map; bit lane*8+row, row 0 is top, row 7 is the hit row.
REQ-010 Hit  output  1  one-cycle pulse, at least one hit this cycle.
REQ-011 Miss  output  1  one-cycle pulse, at least one miss this cycle.
REQ-012 Score  output  8  hit count, saturating at 255.
REQ-013 Misses  output  4  miss count, saturating at MAX_MISS.
REQ-014 State  output  2  00 IDLE, 01 PLAY, 10 OVER; 11 is unreachable.
REQ-015 Combo  output  8  consecutive-hit count (see Configuration).

Function
REQ-016 State machine: IDLE -(Start)-> PLAY; PLAY -(Misses reaches MAX_MISS)-> OVER; OVER -(Start)-> PLAY; all other conditions hold the current state.
REQ-017 Entering PLAY clears Field, Score, Misses and Combo on the same edge; Tick and Key in that cycle are ignored.
REQ-018 In IDLE and OVER, Tick and Key are ignored; Field, Score and Misses hold their values, and Hit and Miss stay 0.
REQ-019 Key evaluation in PLAY, per lane i with Key[i]=1:
- if row 7 of lane i holds a note (pre-shift value), the note is cleared and counts as a hit;
- otherwise the press counts as a miss.
REQ-020 Tick in PLAY: every lane shifts down one row (row r to r+1).
- a note leaving row 7 counts as a miss, unless a Key removed it in the same cycle.
REQ-021 Spawn on Tick: if Rand[8:6] < DENSITY, row 0 of lane Rand[1:0] gets a note; all other row-0 bits become 0.
REQ-022 Tick and Key in the same cycle: keys are judged against pre-shift row 7 first, then the shift applies to the post-key field.
REQ-023 Per-cycle counts:
- hits h (0..4) and misses m (0..8) are summed;
- Score += h, saturating at 255;
- Misses += m, saturating at MAX_MISS.
REQ-024 Hit = (h>0) and Miss = (m>0), both registered and asserted the cycle after the causing edge, for one cycle.
REQ-025 The PLAY->OVER transition occurs on the same edge on which Misses reaches MAX_MISS; the field is frozen from that edge on.
REQ-026 Start in PLAY is ignored.

Reset
REQ-027 Reset takes priority over Start, Tick and Key.
REQ-028 Reset drives State=IDLE and Field=0, Score=0, Misses=0, Combo=0, Hit=0, Miss=0 on the next rising edge.
REQ-029 Reset asserted mid-game discards all pending hits and misses.

Configuration
REQ-030 Macro ARROW_FIELD_COMBO_EN.
- Defined: Combo increments by h each cycle with h>0 and m=0, saturating at 255, and clears to 0 in any cycle with m>0.
- Undefined: no combo logic is built and Combo is constant 0.
- The port list is identical in both cases.

Verification
REQ-031 Reset, then Start, then one Tick with Rand=9'b000_000_010 and DENSITY=4 -> Field bit 16 (lane 2, row 0) = 1; all other bits 0.
REQ-032 Note in lane 0 row 7, Key=4'b0001 with no Tick -> next cycle Hit=1, Score=1, Field bit 7 = 0, Misses unchanged.
REQ-033 Note in lane 3 row 7, then a Tick with no Key -> Miss=1, Misses=1, and the note is gone from Field.
REQ-034 Same cycle: Tick, Key=4'b0011, note at lane 0 row 7, lane 1 row 7 empty -> h=1, m=1, Score+1, Misses+1, Hit=1 and Miss=1; with the macro defined, Combo=0.
REQ-035 MAX_MISS=2, two miss events -> State=OVER on the second; later Ticks and Keys leave Field and Score unchanged; Start -> PLAY with all counters 0.
REQ-036 Reset asserted while in PLAY with Score=5 and Tick high -> next cycle State=IDLE, Score=0, Field=0.
